// File: rtl/mmss_ctrl_pkg.sv
// Shared constants for the MM:SS time controller: state encoding, BCD digit
// limits and blink-select codes.
package mmss_ctrl_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_SET_MIN = 2'd2;
  localparam logic [1:0] ST_SET_SEC = 2'd3;

  localparam logic [3:0] ONES_MAX = 4'd9;
  localparam logic [3:0] TENS_MAX = 4'd5;

  localparam logic [1:0] FLICK_MIN = 2'b10;
  localparam logic [1:0] FLICK_SEC = 2'b01;
  localparam logic [1:0] FLICK_OFF = 2'b00;

endpackage

// File: rtl/bcd_mod60.sv
// Two-digit BCD modulo-60 counter with increment/decrement and wrap flags.
// Increment wins if both requests arrive together.
module bcd_mod60 (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc_i,
  input  logic       dec_i,
  output logic [7:0] val_o,
  output logic       carry_o,
  output logic       borrow_o
);
  import mmss_ctrl_pkg::*;

  logic [3:0] r_ones, r_tens;
  logic [3:0] w_onesInc, w_tensInc, w_onesDec, w_tensDec;
  logic       w_atMax, w_atZero;

  assign w_atMax  = (r_ones == ONES_MAX) && (r_tens == TENS_MAX);
  assign w_atZero = (r_ones == 4'd0) && (r_tens == 4'd0);

  // Per-digit next values; tens only moves when the ones digit rolls over.
  always_comb begin
    w_onesInc = r_ones + 4'd1;
    w_tensInc = r_tens;
    w_onesDec = r_ones - 4'd1;
    w_tensDec = r_tens;
    if (r_ones == ONES_MAX) begin
      w_onesInc = 4'd0;
      w_tensInc = (r_tens == TENS_MAX) ? 4'd0 : r_tens + 4'd1;
    end
    if (r_ones == 4'd0) begin
      w_onesDec = ONES_MAX;
      w_tensDec = (r_tens == 4'd0) ? TENS_MAX : r_tens - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ones <= 4'd0;
      r_tens <= 4'd0;
    end else if (inc_i) begin
      r_ones <= w_onesInc;
      r_tens <= w_tensInc;
    end else if (dec_i) begin
      r_ones <= w_onesDec;
      r_tens <= w_tensDec;
    end
  end

  assign val_o    = {r_tens, r_ones};
  assign carry_o  = inc_i & w_atMax;
  assign borrow_o = dec_i & ~inc_i & w_atZero;

endmodule

// File: rtl/mmss_time_controller.sv
// MM:SS stopwatch controller: button edge detection, run/set FSM, 1 Hz
// prescaler and BCD minute/second registers. Define COUNTDOWN_EN for countdown.
module mmss_time_controller #(
  parameter int CLK_DIV = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start_i,
  input  logic       btn_mode_i,
  input  logic       btn_inc_i,
  output logic [7:0] min_o,
  output logic [7:0] sec_o,
  output logic [1:0] flick_o,
  output logic       running_o,
  output logic       done_o
);
  import mmss_ctrl_pkg::*;

  localparam int PW = $clog2(CLK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);

  logic          r_prevStart, r_prevMode, r_prevInc;
  logic [1:0]    r_state, w_stateNext;
  logic [PW-1:0] r_presc;
  logic          w_modeEv, w_startEv, w_startAct, w_incAct;
  logic          w_tick, w_startOk, w_lastTick;
  logic          w_secInc, w_secDec, w_minInc, w_minDec;
  logic          w_secCarry, w_secBorrow, w_minCarry, w_minBorrow;
  logic          w_unusedFlags;
  logic [7:0]    w_min, w_sec;

  // Prev registers start high so a button held through reset is not an event.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prevStart <= 1'b1;
      r_prevMode  <= 1'b1;
      r_prevInc   <= 1'b1;
    end else begin
      r_prevStart <= btn_start_i;
      r_prevMode  <= btn_mode_i;
      r_prevInc   <= btn_inc_i;
    end
  end

  assign w_modeEv   = btn_mode_i & ~r_prevMode;
  assign w_startEv  = btn_start_i & ~r_prevStart;
  assign w_startAct = w_startEv & ~w_modeEv;
  assign w_incAct   = btn_inc_i & ~r_prevInc & ~w_modeEv & ~w_startEv;
  assign w_tick     = (r_state == ST_RUN) & (r_presc == PRESC_MAX) & ~w_startAct;

`ifdef COUNTDOWN_EN
  assign w_startOk  = w_startAct & ((w_min != 8'h00) | (w_sec != 8'h00));
  assign w_lastTick = w_tick & (w_min == 8'h00) & (w_sec == 8'h01);
  assign w_secInc   = (r_state == ST_SET_SEC) & w_incAct;
  assign w_secDec   = w_tick;
  assign w_minDec   = w_secBorrow;
`else
  assign w_startOk  = w_startAct;
  assign w_lastTick = 1'b0;
  assign w_secInc   = ((r_state == ST_SET_SEC) & w_incAct) | w_tick;
  assign w_secDec   = 1'b0;
  assign w_minDec   = 1'b0;
`endif

  // Seconds carry only ripples into minutes on a tick, never while editing seconds.
  assign w_minInc = ((r_state == ST_SET_MIN) & w_incAct) | (w_tick & w_secCarry);

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_modeEv)       w_stateNext = ST_SET_MIN;
        else if (w_startOk) w_stateNext = ST_RUN;
      end
      ST_RUN: begin
        if (w_startAct || w_lastTick) w_stateNext = ST_IDLE;
      end
      ST_SET_MIN: begin
        if (w_modeEv) w_stateNext = ST_SET_SEC;
      end
      ST_SET_SEC: begin
        if (w_modeEv) w_stateNext = ST_IDLE;
      end
      default: w_stateNext = ST_IDLE;
    endcase
  end

  // Prescaler only survives while staying in RUN, so every restart waits a full period.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_presc <= '0;
    end else begin
      r_state <= w_stateNext;
      if ((r_state == ST_RUN) && (w_stateNext == ST_RUN))
        r_presc <= (r_presc == PRESC_MAX) ? '0 : r_presc + PW'(1);
      else
        r_presc <= '0;
    end
  end

  bcd_mod60 u_sec (
    .clk      (clk),
    .rst      (rst),
    .inc_i    (w_secInc),
    .dec_i    (w_secDec),
    .val_o    (w_sec),
    .carry_o  (w_secCarry),
    .borrow_o (w_secBorrow)
  );

  bcd_mod60 u_min (
    .clk      (clk),
    .rst      (rst),
    .inc_i    (w_minInc),
    .dec_i    (w_minDec),
    .val_o    (w_min),
    .carry_o  (w_minCarry),
    .borrow_o (w_minBorrow)
  );

  assign w_unusedFlags = w_minCarry ^ w_minBorrow ^ w_secBorrow;

`ifdef COUNTDOWN_EN
  logic r_done;
  always_ff @(posedge clk) begin
    if (rst) r_done <= 1'b0;
    else     r_done <= w_lastTick;
  end
  assign done_o = r_done;
`else
  assign done_o = 1'b0;
`endif

  always_comb begin
    flick_o = FLICK_OFF;
    case (r_state)
      ST_SET_MIN: flick_o = FLICK_MIN;
      ST_SET_SEC: flick_o = FLICK_SEC;
      default:    flick_o = FLICK_OFF;
    endcase
  end

  assign min_o     = w_min;
  assign sec_o     = w_sec;
  assign running_o = (r_state == ST_RUN);

endmodule

// File: tb/tb_mmss_time_controller.sv
// Scoreboard bench for mmss_time_controller: stimulus queues expected outputs
// tagged with a cycle number, and a negedge monitor pops and compares them.
module tb_mmss_time_controller;

  localparam int CLK_DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btnStart = 1'b0;
  logic       btnMode = 1'b0;
  logic       btnInc = 1'b0;
  logic [7:0] minOut, secOut;
  logic [1:0] flickOut;
  logic       runningOut, doneOut;

  typedef struct {
    int          cycle;
    string       name;
    logic [19:0] exp;
  } exp_t;

  exp_t sbQueue[$];
  int   cycleCnt = 0;
  int   compared = 0;
  int   mismatched = 0;

  mmss_time_controller #(.CLK_DIV(CLK_DIV)) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_start_i (btnStart),
    .btn_mode_i  (btnMode),
    .btn_inc_i   (btnInc),
    .min_o       (minOut),
    .sec_o       (secOut),
    .flick_o     (flickOut),
    .running_o   (runningOut),
    .done_o      (doneOut)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Monitor: compares every queued expectation due in the current cycle.
  always @(negedge clk) begin
    exp_t        e;
    logic [19:0] act;
    act = {minOut, secOut, flickOut, runningOut, doneOut};
    while (sbQueue.size() > 0 && sbQueue[0].cycle <= cycleCnt) begin
      e = sbQueue.pop_front();
      compared++;
      if (e.cycle < cycleCnt) begin
        mismatched++;
        $display("[TB] FAIL %s: expectation for cycle %0d overdue at cycle %0d",
                 e.name, e.cycle, cycleCnt);
      end else if (act !== e.exp) begin
        mismatched++;
        $display("[TB] FAIL %s: got min=%h sec=%h flick=%b run=%b done=%b, want min=%h sec=%h flick=%b run=%b done=%b",
                 e.name, act[19:12], act[11:4], act[3:2], act[1], act[0],
                 e.exp[19:12], e.exp[11:4], e.exp[3:2], e.exp[1], e.exp[0]);
      end
    end
  end

  function automatic logic [7:0] toBcd(input int v);
    logic [3:0] tens, ones;
    tens = 4'(v / 10);
    ones = 4'(v % 10);
    return {tens, ones};
  endfunction

  task automatic checkOutput(input string name, input int offset,
                             input logic [7:0] minE, input logic [7:0] secE,
                             input logic [1:0] flickE, input logic runE,
                             input logic doneE);
    exp_t e;
    e.cycle = cycleCnt + offset;
    e.name  = name;
    e.exp   = {minE, secE, flickE, runE, doneE};
    sbQueue.push_back(e);
  endtask

  // One press: level rises one cycle, event lands on the second edge, then releases.
  task automatic applyStimulus(input logic s, input logic m, input logic i);
    @(posedge clk);
    #1;
    btnStart = s;
    btnMode  = m;
    btnInc   = i;
    @(posedge clk);
    #1;
    btnStart = 1'b0;
    btnMode  = 1'b0;
    btnInc   = 1'b0;
  endtask

  task automatic pressInc(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 1'b1);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // Start held through reset must not be seen as a press.
    btnStart = 1'b1;
    waitCycles(3);
    checkOutput("reset_values", 0, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0);
    rst = 1'b0;
    checkOutput("held_start_no_run", 1, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0);
    checkOutput("held_start_still_idle", 3, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0);
    waitCycles(4);
    btnStart = 1'b0;
    waitCycles(2);
    checkOutput("release_idle", 0, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0);

    // Set-mode edits with wrap of each field.
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("enter_set_min", 0, 8'h00, 8'h00, 2'b10, 1'b0, 1'b0);
    pressInc(58);
    checkOutput("min_58", 0, 8'h58, 8'h00, 2'b10, 1'b0, 1'b0);
    pressInc(1);
    checkOutput("min_59", 0, 8'h59, 8'h00, 2'b10, 1'b0, 1'b0);
    pressInc(1);
    checkOutput("min_wrap_00", 0, 8'h00, 8'h00, 2'b10, 1'b0, 1'b0);
    pressInc(1);
    checkOutput("min_01", 0, 8'h01, 8'h00, 2'b10, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("enter_set_sec", 0, 8'h01, 8'h00, 2'b01, 1'b0, 1'b0);
    pressInc(59);
    checkOutput("sec_59", 0, 8'h01, 8'h59, 2'b01, 1'b0, 1'b0);
    pressInc(1);
    checkOutput("sec_wrap_min_kept", 0, 8'h01, 8'h00, 2'b01, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("back_to_idle", 0, 8'h01, 8'h00, 2'b00, 1'b0, 1'b0);

`ifdef COUNTDOWN_EN
    // Countdown from 01:00 down to 00:00, one tick every CLK_DIV cycles.
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("cd_start", 0, 8'h01, 8'h00, 2'b00, 1'b1, 1'b0);
    checkOutput("cd_before_tick", 3, 8'h01, 8'h00, 2'b00, 1'b1, 1'b0);
    for (int k = 1; k < 60; k++)
      checkOutput($sformatf("cd_tick_%0d", k), 4 * k, 8'h00, toBcd(60 - k),
                  2'b00, 1'b1, 1'b0);
    checkOutput("cd_expire_done", 240, 8'h00, 8'h00, 2'b00, 1'b0, 1'b1);
    checkOutput("cd_done_one_cycle", 241, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0);
    waitCycles(241);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("cd_start_at_zero_ignored", 0, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0);
    checkOutput("cd_start_at_zero_no_done", 1, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0);
    waitCycles(1);
`else
    // Load 00:58 and count up through the minute carry.
    applyStimulus(1'b0, 1'b1, 1'b0);
    pressInc(59);
    checkOutput("min_to_00", 0, 8'h00, 8'h00, 2'b10, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    pressInc(58);
    checkOutput("sec_to_58", 0, 8'h00, 8'h58, 2'b01, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("run_entry", 0, 8'h00, 8'h58, 2'b00, 1'b1, 1'b0);
    checkOutput("no_early_tick", 3, 8'h00, 8'h58, 2'b00, 1'b1, 1'b0);
    checkOutput("first_tick", 4, 8'h00, 8'h59, 2'b00, 1'b1, 1'b0);
    checkOutput("between_ticks", 7, 8'h00, 8'h59, 2'b00, 1'b1, 1'b0);
    checkOutput("minute_carry", 8, 8'h01, 8'h00, 2'b00, 1'b1, 1'b0);
    // Stop lands on the same edge as the third tick; stop wins.
    waitCycles(10);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("stop_beats_tick", 0, 8'h01, 8'h00, 2'b00, 1'b0, 1'b0);
    waitCycles(5);
    checkOutput("stopped_holds", 0, 8'h01, 8'h00, 2'b00, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("restart_full_wait", 3, 8'h01, 8'h00, 2'b00, 1'b1, 1'b0);
    checkOutput("restart_tick", 4, 8'h01, 8'h01, 2'b00, 1'b1, 1'b0);
    waitCycles(4);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("stop_again", 0, 8'h01, 8'h01, 2'b00, 1'b0, 1'b0);

    // 59:59 wraps to 00:00 and keeps running.
    applyStimulus(1'b0, 1'b1, 1'b0);
    pressInc(58);
    checkOutput("min_to_59", 0, 8'h59, 8'h01, 2'b10, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    pressInc(58);
    checkOutput("sec_to_59", 0, 8'h59, 8'h59, 2'b01, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("run_from_5959", 3, 8'h59, 8'h59, 2'b00, 1'b1, 1'b0);
    checkOutput("wrap_to_0000", 4, 8'h00, 8'h00, 2'b00, 1'b1, 1'b0);
    checkOutput("still_running", 5, 8'h00, 8'h00, 2'b00, 1'b1, 1'b0);
    waitCycles(5);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("stop_after_wrap", 0, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0);
`endif

    // Mode and start together from IDLE: mode wins.
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("mode_beats_start", 0, 8'h00, 8'h00, 2'b10, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    pressInc(1);
    checkOutput("set_sec_01", 0, 8'h00, 8'h01, 2'b01, 1'b0, 1'b0);

    // Reset mid-SET with every button high.
    btnStart = 1'b1;
    btnMode  = 1'b1;
    btnInc   = 1'b1;
    rst      = 1'b1;
    waitCycles(1);
    checkOutput("reset_mid_set", 0, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0);
    rst = 1'b0;
    checkOutput("held_buttons_ignored", 2, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0);
    waitCycles(3);
    btnStart = 1'b0;
    btnMode  = 1'b0;
    btnInc   = 1'b0;

    // Drain the scoreboard with a bounded wait.
    for (int w = 0; w < 50 && sbQueue.size() > 0; w++) @(posedge clk);
    @(negedge clk);
    while (sbQueue.size() > 0) begin
      exp_t e;
      e = sbQueue.pop_front();
      compared++;
      mismatched++;
      $display("[TB] FAIL %s: never compared, due cycle %0d, now %0d",
               e.name, e.cycle, cycleCnt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
